// File: rtl/cond_event_counter_pkg.sv
// Shared types and constants for the conditional event counter.
// The FSM encoding is visible on io_fsm, so the enum values are fixed.
package cond_event_counter_pkg;

    // Control FSM states; the encodings are observed directly on io_fsm
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } fsm_e;

    // Width of the optional wrap-event counter
    localparam int WRAPCNT_W = 16;

endpackage

// File: rtl/cond_event_counter_popcount.sv
// Purely combinational population count over an N-bit condition vector.
// The result width is just wide enough to hold N itself.
module cond_popcount #(
    parameter int N = 2
) (
    input  logic [N-1:0]             vec,
    output logic [$clog2(N+1)-1:0]   cnt
);

    localparam int CW = $clog2(N + 1);

    // Add up every asserted bit of the input vector
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/cond_event_counter.sv
// Conditional event counter: each cycle adds the number of asserted
// condition inputs to a registered count, with wrap or saturate terminal
// behaviour and a 4-state control FSM (IDLE / COUNT / HOLD / DONE).
//
// Optional feature, enabled by defining COND_EVENT_COUNTER_WRAPCNT_EN:
// adds io_wrap_cnt, a 16-bit saturating count of io_wrap pulses.
module cond_event_counter
    import cond_event_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_COND = 2,
    parameter int TERMINAL = 2**WIDTH - 1,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_COND-1:0]  io_cond,
    input  logic                 io_hold,
    input  logic                 io_clear,
    output logic [WIDTH-1:0]     io_state,
    output logic                 io_flag,
    output logic                 io_wrap,
    output logic [1:0]           io_fsm
`ifdef COND_EVENT_COUNTER_WRAPCNT_EN
    ,
    output logic [WRAPCNT_W-1:0] io_wrap_cnt
`endif
);

    // Popcount width and terminal constants, the latter in the widened
    // sum domain so that count+p never overflows before it is compared.
    localparam int               PW       = $clog2(NUM_COND + 1);
    localparam logic [WIDTH:0]   TERM_EXT = (WIDTH+1)'(TERMINAL);
    localparam logic [WIDTH:0]   PERIOD   = (WIDTH+1)'(TERMINAL + 1);
    localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);

    fsm_e             r_state;
    fsm_e             w_nextState;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_nextCount;
    logic             r_wrap;
    logic             w_nextWrap;

    logic [PW-1:0]    w_p;
    logic [WIDTH:0]   w_sum;

    cond_popcount #(
        .N   (NUM_COND)
    ) u_popcount (
        .vec (io_cond),
        .cnt (w_p)
    );

    // Candidate next count, one bit wider than the counter
    assign w_sum = {1'b0, r_count} + (WIDTH+1)'(w_p);

    // State, count and wrap-pulse registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_wrap  <= w_nextWrap;
        end
    end

    // Next-state and datapath decision: clear beats hold beats counting
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextWrap  = 1'b0;

        if (io_clear) begin
            w_nextState = IDLE;
            w_nextCount = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Hold has nothing to freeze at zero, so it just keeps IDLE
                    if (!io_hold && (w_p != '0)) begin
                        w_nextCount = WIDTH'(w_p);
                        w_nextState = COUNT;
                    end
                end

                COUNT: begin
                    if (io_hold) begin
                        w_nextState = HOLD;
                    end else if (w_p != '0) begin
                        if (SATURATE != 0) begin
                            if (w_sum >= TERM_EXT) begin
                                w_nextCount = TERM_VAL;
                                w_nextState = DONE;
                            end else begin
                                w_nextCount = WIDTH'(w_sum);
                            end
                        end else begin
                            // A single step never spans more than one period
                            if (w_sum > TERM_EXT) begin
                                w_nextCount = WIDTH'(w_sum - PERIOD);
                                w_nextWrap  = 1'b1;
                            end else begin
                                w_nextCount = WIDTH'(w_sum);
                            end
                        end
                    end
                end

                HOLD: begin
                    // Conditions present in the release cycle are dropped
                    if (!io_hold) begin
                        w_nextState = COUNT;
                    end
                end

                DONE: begin
                    w_nextCount = TERM_VAL;
                end

                default: begin
                    w_nextState = IDLE;
                    w_nextCount = '0;
                end
            endcase
        end
    end

`ifdef COND_EVENT_COUNTER_WRAPCNT_EN
    logic [WRAPCNT_W-1:0] r_wrapCnt;

    // Count wrap events on the same edge the io_wrap pulse is registered
    always_ff @(posedge clk) begin
        if (reset || io_clear) begin
            r_wrapCnt <= '0;
        end else if (w_nextWrap && (r_wrapCnt != {WRAPCNT_W{1'b1}})) begin
            r_wrapCnt <= r_wrapCnt + 1'b1;
        end
    end

    assign io_wrap_cnt = r_wrapCnt;
`else
    // Without the wrap-event counter the outputs below are the whole interface
`endif

    assign io_state = r_count;
    assign io_flag  = (r_count == '0);
    assign io_wrap  = r_wrap;
    assign io_fsm   = r_state;

endmodule

// File: tb/tb_cond_event_counter.sv
// Self-checking bench for cond_event_counter: a wrap-mode instance
// (TERMINAL=9) driven from a directed vector table, and a saturate-mode
// instance (TERMINAL=200) exercised by a hand-written sequence. Both share
// the same input wires; only the instance under test is checked per phase.
module tb_cond_event_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ioClear;
    logic       ioHold;
    logic [1:0] ioCond;

    logic [7:0] wrapState;
    logic       wrapFlag;
    logic       wrapPulse;
    logic [1:0] wrapFsm;

    logic [7:0] satState;
    logic       satFlag;
    logic       satPulse;
    logic [1:0] satFsm;

`ifdef COND_EVENT_COUNTER_WRAPCNT_EN
    logic [15:0] wrapCntA;
    logic [15:0] wrapCntB;
`endif

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       hld;
        logic [1:0] cond;
        int         expState;
        int         expFlag;
        int         expWrap;
        int         expFsm;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cond_event_counter #(
        .WIDTH    (8),
        .NUM_COND (2),
        .TERMINAL (9),
        .SATURATE (0)
    ) dutWrap (
        .clk      (clk),
        .reset    (reset),
        .io_cond  (ioCond),
        .io_hold  (ioHold),
        .io_clear (ioClear),
        .io_state (wrapState),
        .io_flag  (wrapFlag),
        .io_wrap  (wrapPulse),
        .io_fsm   (wrapFsm)
`ifdef COND_EVENT_COUNTER_WRAPCNT_EN
        ,
        .io_wrap_cnt (wrapCntA)
`endif
    );

    cond_event_counter #(
        .WIDTH    (8),
        .NUM_COND (2),
        .TERMINAL (200),
        .SATURATE (1)
    ) dutSat (
        .clk      (clk),
        .reset    (reset),
        .io_cond  (ioCond),
        .io_hold  (ioHold),
        .io_clear (ioClear),
        .io_state (satState),
        .io_flag  (satFlag),
        .io_wrap  (satPulse),
        .io_fsm   (satFsm)
`ifdef COND_EVENT_COUNTER_WRAPCNT_EN
        ,
        .io_wrap_cnt (wrapCntB)
`endif
    );

    // Append one table row: inputs, then expected state/flag/wrap/fsm
    function automatic void v(input logic r, input logic c, input logic h,
                              input logic [1:0] cond, input int st,
                              input int fl, input int wr, input int fsm);
        vec_t e;
        e.rst = r; e.clr = c; e.hld = h; e.cond = cond;
        e.expState = st; e.expFlag = fl; e.expWrap = wr; e.expFsm = fsm;
        vecs.push_back(e);
    endfunction

    // Drive inputs for one cycle and return 1 time unit after the edge
    task automatic applyStimulus(input logic r, input logic c, input logic h,
                                 input logic [1:0] cond);
        reset   = r;
        ioClear = c;
        ioHold  = h;
        ioCond  = cond;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual,
                               input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        int  expSat;
        int  expSatFsm;
        int  wrapSeen;
        int  pulses;

        reset   = 1'b1;
        ioClear = 1'b0;
        ioHold  = 1'b0;
        ioCond  = 2'b11;

        // Reset with conditions active, then idle with no conditions
        v(1,0,0,2'b11, 0,1,0,0);
        v(1,0,0,2'b11, 0,1,0,0);
        v(0,0,0,2'b00, 0,1,0,0);
        // One event per cycle: 1..9, wrap to 0, then 1, 2
        v(0,0,0,2'b01, 1,0,0,1);
        v(0,0,0,2'b01, 2,0,0,1);
        v(0,0,0,2'b01, 3,0,0,1);
        v(0,0,0,2'b01, 4,0,0,1);
        v(0,0,0,2'b01, 5,0,0,1);
        v(0,0,0,2'b01, 6,0,0,1);
        v(0,0,0,2'b01, 7,0,0,1);
        v(0,0,0,2'b01, 8,0,0,1);
        v(0,0,0,2'b01, 9,0,0,1);
        v(0,0,0,2'b01, 0,1,1,1);
        v(0,0,0,2'b01, 1,0,0,1);
        v(0,0,0,2'b01, 2,0,0,1);
        // Clear, then two events per cycle: 2,4,6,8, wrap to 0, 2
        v(0,1,0,2'b11, 0,1,0,0);
        v(0,0,0,2'b11, 2,0,0,1);
        v(0,0,0,2'b11, 4,0,0,1);
        v(0,0,0,2'b11, 6,0,0,1);
        v(0,0,0,2'b11, 8,0,0,1);
        v(0,0,0,2'b11, 0,1,1,1);
        v(0,0,0,2'b11, 2,0,0,1);
        // Climb to 9, then a double step wraps to 1
        v(0,0,0,2'b01, 3,0,0,1);
        v(0,0,0,2'b01, 4,0,0,1);
        v(0,0,0,2'b01, 5,0,0,1);
        v(0,0,0,2'b01, 6,0,0,1);
        v(0,0,0,2'b01, 7,0,0,1);
        v(0,0,0,2'b01, 8,0,0,1);
        v(0,0,0,2'b01, 9,0,0,1);
        v(0,0,0,2'b11, 1,0,1,1);
        v(0,0,0,2'b00, 1,0,0,1);
        // Count to 5, hold three cycles, then hold+clear together
        v(0,1,0,2'b00, 0,1,0,0);
        v(0,0,0,2'b01, 1,0,0,1);
        v(0,0,0,2'b01, 2,0,0,1);
        v(0,0,0,2'b01, 3,0,0,1);
        v(0,0,0,2'b01, 4,0,0,1);
        v(0,0,0,2'b01, 5,0,0,1);
        v(0,0,1,2'b11, 5,0,0,2);
        v(0,0,1,2'b11, 5,0,0,2);
        v(0,0,1,2'b11, 5,0,0,2);
        v(0,1,1,2'b11, 0,1,0,0);
        // Hold release drops that cycle's conditions; counting resumes after
        v(0,0,0,2'b01, 1,0,0,1);
        v(0,0,0,2'b01, 2,0,0,1);
        v(0,0,0,2'b01, 3,0,0,1);
        v(0,0,0,2'b01, 4,0,0,1);
        v(0,0,0,2'b01, 5,0,0,1);
        v(0,0,1,2'b11, 5,0,0,2);
        v(0,0,0,2'b11, 5,0,0,1);
        v(0,0,0,2'b11, 7,0,0,1);
        v(0,0,0,2'b00, 7,0,0,1);
        // Reset while in HOLD at count 7
        v(0,0,1,2'b00, 7,0,0,2);
        v(1,0,1,2'b11, 0,1,0,0);
        v(1,0,1,2'b11, 0,1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].hld, vecs[i].cond);
            checkOutput($sformatf("vec%0d state", i), int'(wrapState), vecs[i].expState);
            checkOutput($sformatf("vec%0d flag", i),  int'(wrapFlag),  vecs[i].expFlag);
            checkOutput($sformatf("vec%0d wrap", i),  int'(wrapPulse), vecs[i].expWrap);
            checkOutput($sformatf("vec%0d fsm", i),   int'(wrapFsm),   vecs[i].expFsm);
        end

        // Saturate mode: two events per cycle reach 200 after cycle 100
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11);
        checkOutput("sat reset state", int'(satState), 0);
        checkOutput("sat reset fsm",   int'(satFsm),   0);
        wrapSeen = 0;
        for (int k = 1; k <= 105; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'b11);
            expSat    = (2 * k > 200) ? 200 : 2 * k;
            expSatFsm = (k >= 100) ? 3 : 1;
            if (satPulse) wrapSeen++;
            checkOutput($sformatf("sat cyc%0d state", k), int'(satState), expSat);
            checkOutput($sformatf("sat cyc%0d fsm", k),   int'(satFsm),   expSatFsm);
        end
        checkOutput("sat wrap pulses", wrapSeen, 0);
        // DONE ignores hold and conditions; only clear leaves it
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11);
        checkOutput("sat done hold state", int'(satState), 200);
        checkOutput("sat done hold fsm",   int'(satFsm),   3);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11);
        checkOutput("sat clear state", int'(satState), 0);
        checkOutput("sat clear flag",  int'(satFlag),  1);
        checkOutput("sat clear fsm",   int'(satFsm),   0);

        // Fifty single events in wrap mode give five wrap pulses
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
        pulses = 0;
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'b01);
            if (wrapPulse) pulses++;
        end
        checkOutput("wrap pulse total", pulses, 5);
        checkOutput("wrap 50 state", int'(wrapState), 0);
`ifdef COND_EVENT_COUNTER_WRAPCNT_EN
        checkOutput("wrap_cnt after 50", int'(wrapCntA), 5);
        checkOutput("wrap_cnt sat inst", int'(wrapCntB), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01);
        checkOutput("wrap_cnt cleared", int'(wrapCntA), 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
